// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Desc     : Shared opcode, flag-index and state encodings for alu_seq.
// Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam logic [3:0] c_op_and = 4'h0;
    localparam logic [3:0] c_op_eor = 4'h1;
    localparam logic [3:0] c_op_sub = 4'h2;
    localparam logic [3:0] c_op_rsb = 4'h3;
    localparam logic [3:0] c_op_add = 4'h4;
    localparam logic [3:0] c_op_adc = 4'h5;
    localparam logic [3:0] c_op_sbc = 4'h6;
    localparam logic [3:0] c_op_rsc = 4'h7;
    localparam logic [3:0] c_op_tst = 4'h8;
    localparam logic [3:0] c_op_teq = 4'h9;
    localparam logic [3:0] c_op_cmp = 4'hA;
    localparam logic [3:0] c_op_cmn = 4'hB;
    localparam logic [3:0] c_op_orr = 4'hC;
    localparam logic [3:0] c_op_mov = 4'hD;
    localparam logic [3:0] c_op_bic = 4'hE;
    localparam logic [3:0] c_op_mvn = 4'hF;

    localparam int c_flag_n = 3;
    localparam int c_flag_z = 2;
    localparam int c_flag_c = 1;
    localparam int c_flag_v = 0;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // TST/TEQ/CMP/CMN occupy 8..11: always set flags, never write Rd.
    function automatic logic op_is_test(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_mul.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_mul
// Desc     : Iterative shift-add multiplier, MUL_BITS_PER_CYCLE bits per step.
// Config   : ALU_SEQ_EARLY_TERM_EN - stop once remaining multiplier bits are 0.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_mul #(
    parameter int WIDTH              = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             acc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int c_iters = WIDTH / MUL_BITS_PER_CYCLE;
    localparam int c_cw    = $clog2(c_iters + 1);
    localparam logic [c_cw-1:0] c_iter_cnt = c_cw'(c_iters);
    localparam logic [c_cw-1:0] c_last     = c_cw'(1);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [c_cw-1:0]  r_count;
    logic [WIDTH-1:0] w_partial;
    logic [WIDTH-1:0] w_acc_nxt;

    always_comb begin
        w_partial = '0;
        for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
            if (r_mplier[i]) begin
                w_partial = w_partial + (r_mcand << i);
            end
        end
        w_acc_nxt = r_acc + w_partial;
    end

    assign busy    = (r_count != '0);
    assign product = w_acc_nxt;

`ifdef ALU_SEQ_EARLY_TERM_EN
    logic [WIDTH-1:0] w_rest;
    assign w_rest = r_mplier >> MUL_BITS_PER_CYCLE;
    assign done   = busy && ((r_count == c_last) || (w_rest == '0));
`else
    assign done   = busy && (r_count == c_last);
`endif

    // product is combinational on the final step so the caller can register it on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (start) begin
            r_acc    <= acc ? c : '0;
            r_mcand  <= a;
            r_mplier <= b;
            r_count  <= c_iter_cnt;
        end else if (busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << MUL_BITS_PER_CYCLE;
            r_mplier <= r_mplier >> MUL_BITS_PER_CYCLE;
            r_count  <= done ? '0 : r_count - c_last;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Desc     : Registered ARM data-processing ALU with iterative MUL/MLA and
//            valid/ready handshakes on request and result sides.
// Config   : ALU_SEQ_EARLY_TERM_EN - early exit of the multiply iteration.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH              = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic             is_mul,
    input  logic             accumulate,
    input  logic             setflags,
    input  logic [WIDTH-1:0] dataina,
    input  logic [WIDTH-1:0] datainb,
    input  logic [WIDTH-1:0] datainc,
    input  logic             shiftcarry,
    input  logic [3:0]       flagsin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataout,
    output logic [3:0]       flagsout,
    output logic             writeback
);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_dataout;
    logic [3:0]       r_flagsout;
    logic             r_writeback;
    logic [3:0]       r_mul_flags;
    logic             r_mul_s;

    logic [1:0]       w_state_nxt;
    logic             w_accept;
    logic             w_ld_alu;
    logic             w_ld_mul;
    logic             w_mul_start;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_product;
    logic [3:0]       w_mul_flags;

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic             w_arith;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_logic;
    logic [WIDTH-1:0] w_res;
    logic [3:0]       w_alu_flags;

    alu_seq_mul #(
        .WIDTH              (WIDTH),
        .MUL_BITS_PER_CYCLE (MUL_BITS_PER_CYCLE)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (dataina),
        .b       (datainb),
        .c       (datainc),
        .acc     (accumulate),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_product)
    );

    // Subtract-type ops add the inverted operand, so carry-out is already NOT-borrow.
    always_comb begin
        w_x     = dataina;
        w_y     = datainb;
        w_cin   = 1'b0;
        w_arith = 1'b1;
        case (opcode)
            c_op_sub, c_op_cmp: begin w_y = ~datainb; w_cin = 1'b1; end
            c_op_sbc:           begin w_y = ~datainb; w_cin = flagsin[c_flag_c]; end
            c_op_rsb:           begin w_x = datainb; w_y = ~dataina; w_cin = 1'b1; end
            c_op_rsc:           begin w_x = datainb; w_y = ~dataina; w_cin = flagsin[c_flag_c]; end
            c_op_add, c_op_cmn: w_cin = 1'b0;
            c_op_adc:           w_cin = flagsin[c_flag_c];
            default:            w_arith = 1'b0;
        endcase
        w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};

        case (opcode)
            c_op_and, c_op_tst: w_logic = dataina & datainb;
            c_op_eor, c_op_teq: w_logic = dataina ^ datainb;
            c_op_orr:           w_logic = dataina | datainb;
            c_op_mov:           w_logic = datainb;
            c_op_bic:           w_logic = dataina & ~datainb;
            c_op_mvn:           w_logic = ~datainb;
            default:            w_logic = '0;
        endcase
        w_res = w_arith ? w_sum[WIDTH-1:0] : w_logic;

        w_alu_flags = flagsin;
        if (setflags || op_is_test(opcode)) begin
            w_alu_flags[c_flag_n] = w_res[WIDTH-1];
            w_alu_flags[c_flag_z] = (w_res == '0);
            w_alu_flags[c_flag_c] = w_arith ? w_sum[WIDTH] : shiftcarry;
            if (w_arith) begin
                w_alu_flags[c_flag_v] = (w_x[WIDTH-1] == w_y[WIDTH-1]) &&
                                        (w_res[WIDTH-1] != w_x[WIDTH-1]);
            end
        end
    end

    always_comb begin
        w_mul_flags = r_mul_flags;
        if (r_mul_s) begin
            w_mul_flags[c_flag_n] = w_product[WIDTH-1];
            w_mul_flags[c_flag_z] = (w_product == '0);
        end
    end

    assign in_ready = ((r_state == c_st_idle) && !w_mul_busy) ||
                      ((r_state == c_st_done) && out_ready);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_ld_alu    = 1'b0;
        w_ld_mul    = 1'b0;
        w_mul_start = 1'b0;
        case (r_state)
            c_st_mul: begin
                if (w_mul_done) begin
                    w_state_nxt = c_st_done;
                    w_ld_mul    = 1'b1;
                end
            end
            c_st_done: if (out_ready) w_state_nxt = c_st_idle;
            c_st_idle: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
        // An accept in DONE behaves exactly like one in IDLE.
        if (w_accept) begin
            if (is_mul) begin
                w_state_nxt = c_st_mul;
                w_mul_start = 1'b1;
            end else begin
                w_state_nxt = c_st_done;
                w_ld_alu    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_dataout   <= '0;
            r_flagsout  <= '0;
            r_writeback <= 1'b0;
            r_mul_flags <= '0;
            r_mul_s     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_mul_start) begin
                r_mul_flags <= flagsin;
                r_mul_s     <= setflags;
            end
            if (w_ld_alu) begin
                r_dataout   <= w_res;
                r_flagsout  <= w_alu_flags;
                r_writeback <= !op_is_test(opcode);
            end else if (w_ld_mul) begin
                r_dataout   <= w_product;
                r_flagsout  <= w_mul_flags;
                r_writeback <= 1'b1;
            end
        end
    end

    assign out_valid = (r_state == c_st_done);
    assign dataout   = r_dataout;
    assign flagsout  = r_flagsout;
    assign writeback = r_writeback;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Desc     : Directed-vector bench for alu_seq (1 and 4 multiplier bits/cycle).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam logic [3:0] AND_ = 4'h0, EOR_ = 4'h1, SUB_ = 4'h2, RSB_ = 4'h3;
    localparam logic [3:0] ADD_ = 4'h4, ADC_ = 4'h5, SBC_ = 4'h6, RSC_ = 4'h7;
    localparam logic [3:0] TST_ = 4'h8, TEQ_ = 4'h9, CMP_ = 4'hA, CMN_ = 4'hB;
    localparam logic [3:0] ORR_ = 4'hC, MOV_ = 4'hD, BIC_ = 4'hE, MVN_ = 4'hF;

`ifdef ALU_SEQ_EARLY_TERM_EN
    localparam int MLA_LAT1 = 18;
    localparam int MLA_LAT4 = 6;
`else
    localparam int MLA_LAT1 = 33;
    localparam int MLA_LAT4 = 9;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready;
    logic [3:0]  opcode;
    logic        is_mul, accumulate, setflags, shiftcarry;
    logic [31:0] dataina, datainb, datainc;
    logic [3:0]  flagsin;
    logic        ir1, ov1, wb1, ir4, ov4, wb4;
    logic [31:0] do1, do4;
    logic [3:0]  fo1, fo4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .opcode(opcode),
        .is_mul(is_mul), .accumulate(accumulate), .setflags(setflags),
        .dataina(dataina), .datainb(datainb), .datainc(datainc),
        .shiftcarry(shiftcarry), .flagsin(flagsin), .out_valid(ov1),
        .out_ready(out_ready), .dataout(do1), .flagsout(fo1), .writeback(wb1)
    );

    alu_seq #(.WIDTH(32), .MUL_BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .opcode(opcode),
        .is_mul(is_mul), .accumulate(accumulate), .setflags(setflags),
        .dataina(dataina), .datainb(datainb), .datainc(datainc),
        .shiftcarry(shiftcarry), .flagsin(flagsin), .out_valid(ov4),
        .out_ready(out_ready), .dataout(do4), .flagsout(fo4), .writeback(wb4)
    );

    typedef struct {
        logic [3:0]  op;
        logic        mul;
        logic        acc;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        sc;
        logic [3:0]  fin;
        logic [31:0] ed;
        logic [3:0]  ef;
        logic        ew;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        opcode = v.op; is_mul = v.mul; accumulate = v.acc; setflags = v.s;
        dataina = v.a; datainb = v.b; datainc = v.c; shiftcarry = v.sc; flagsin = v.fin;
    endtask

    task automatic scramble();
        dataina = ~dataina; datainb = 32'h1234_5678; datainc = ~datainc;
        flagsin = ~flagsin; shiftcarry = ~shiftcarry; opcode = ~opcode;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        @(posedge clk); #1;
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!ir1 && n < 50) begin @(posedge clk); #1; n++; end
        chk($sformatf("v%0d in_ready", idx), {31'b0, ir1}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        n = 0;
        while (!ov1 && n < 100) begin @(posedge clk); #1; n++; end
        chk($sformatf("v%0d out_valid", idx), {31'b0, ov1}, 32'd1);
        if (!v.mul) chk($sformatf("v%0d latency", idx), n, 0);
        chk($sformatf("v%0d dataout", idx), do1, v.ed);
        chk($sformatf("v%0d flagsout", idx), {28'b0, fo1}, {28'b0, v.ef});
        chk($sformatf("v%0d writeback", idx), {31'b0, wb1}, {31'b0, v.ew});
    endtask

    initial begin
        int lat1, lat4, spur;
        vec_t tmp;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode = 4'h0; is_mul = 1'b0; accumulate = 1'b0; setflags = 1'b0;
        dataina = '0; datainb = '0; datainc = '0; shiftcarry = 1'b0; flagsin = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {31'b0, ov1}, 32'd0);
        chk("reset dataout", do1, 32'd0);
        chk("reset flagsout", {28'b0, fo1}, 32'd0);
        chk("reset writeback", {31'b0, wb1}, 32'd0);
        chk("reset in_ready", {31'b0, ir1}, 32'd1);
        rst = 1'b0;

        //          op    mul   acc   s     a             b             c             sc    fin      ed            ef       ew
        vecs[0]  = '{ADD_, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b0, 4'b0000, 32'h00000000, 4'b0110, 1'b1};
        vecs[1]  = '{SUB_, 1'b0, 1'b0, 1'b1, 32'h00000005, 32'h00000007, 32'h0,        1'b0, 4'b0000, 32'hFFFFFFFE, 4'b1000, 1'b1};
        vecs[2]  = '{CMP_, 1'b0, 1'b0, 1'b0, 32'h00000007, 32'h00000005, 32'h0,        1'b0, 4'b0000, 32'h00000002, 4'b0010, 1'b0};
        vecs[3]  = '{ADD_, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h0,        1'b0, 4'b0000, 32'h80000000, 4'b1001, 1'b1};
        vecs[4]  = '{AND_, 1'b0, 1'b0, 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        1'b1, 4'b0001, 32'h00F000F0, 4'b0011, 1'b1};
        vecs[5]  = '{ADC_, 1'b0, 1'b0, 1'b1, 32'h00000001, 32'h00000002, 32'h0,        1'b0, 4'b0010, 32'h00000004, 4'b0000, 1'b1};
        vecs[6]  = '{SBC_, 1'b0, 1'b0, 1'b1, 32'h00000005, 32'h00000003, 32'h0,        1'b0, 4'b0000, 32'h00000001, 4'b0010, 1'b1};
        vecs[7]  = '{RSB_, 1'b0, 1'b0, 1'b0, 32'h00000003, 32'h0000000A, 32'h0,        1'b0, 4'b1010, 32'h00000007, 4'b1010, 1'b1};
        vecs[8]  = '{RSC_, 1'b0, 1'b0, 1'b1, 32'h00000003, 32'h0000000A, 32'h0,        1'b0, 4'b0010, 32'h00000007, 4'b0010, 1'b1};
        vecs[9]  = '{EOR_, 1'b0, 1'b0, 1'b0, 32'h000000FF, 32'h0000000F, 32'h0,        1'b0, 4'b0101, 32'h000000F0, 4'b0101, 1'b1};
        vecs[10] = '{TEQ_, 1'b0, 1'b0, 1'b0, 32'h00000055, 32'h00000055, 32'h0,        1'b0, 4'b0001, 32'h00000000, 4'b0101, 1'b0};
        vecs[11] = '{CMN_, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h0,        1'b0, 4'b0000, 32'h00000000, 4'b0111, 1'b0};
        vecs[12] = '{ORR_, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'h00000001, 32'h0,        1'b0, 4'b0000, 32'h80000001, 4'b1000, 1'b1};
        vecs[13] = '{MOV_, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'h00000000, 32'h0,        1'b1, 4'b0000, 32'h00000000, 4'b0110, 1'b1};
        vecs[14] = '{BIC_, 1'b0, 1'b0, 1'b0, 32'h000000FF, 32'h0000000F, 32'h0,        1'b1, 4'b0000, 32'h000000F0, 4'b0000, 1'b1};
        vecs[15] = '{MVN_, 1'b0, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 32'h0,        1'b0, 4'b0001, 32'hFFFFFFFF, 4'b1001, 1'b1};
        vecs[16] = '{TST_, 1'b0, 1'b0, 1'b0, 32'h00000001, 32'h00000002, 32'h0,        1'b1, 4'b1000, 32'h00000000, 4'b0110, 1'b0};
        vecs[17] = '{SUB_, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'h00000001, 32'h0,        1'b0, 4'b0000, 32'h7FFFFFFF, 4'b0011, 1'b1};
        vecs[18] = '{4'h0, 1'b1, 1'b0, 1'b0, 32'h00000003, 32'h00000005, 32'h0,        1'b0, 4'b1111, 32'h0000000F, 4'b1111, 1'b1};
        vecs[19] = '{4'h0, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b0, 4'b0011, 32'h00000001, 4'b0011, 1'b1};
        vecs[20] = '{4'h0, 1'b1, 1'b1, 1'b1, 32'h00000002, 32'h00000003, 32'hFFFFFFFF, 1'b0, 4'b0000, 32'h00000005, 4'b0000, 1'b1};
        vecs[21] = '{4'h0, 1'b1, 1'b0, 1'b1, 32'h00010000, 32'h00010000, 32'h0,        1'b0, 4'b1100, 32'h00000000, 4'b0100, 1'b1};
        vecs[22] = '{4'h0, 1'b1, 1'b0, 1'b1, 32'h00000007, 32'h00000000, 32'h0,        1'b0, 4'b1011, 32'h00000000, 4'b0111, 1'b1};

        for (int i = 0; i < 23; i++) run_vec(vecs[i], i);

        // Backpressure: result held, no bubble once out_ready rises with a pending request.
        @(posedge clk); #1;
        tmp = '{ADD_, 1'b0, 1'b0, 1'b0, 32'h2, 32'h3, 32'h0, 1'b0, 4'b1010, 32'h0, 4'h0, 1'b0};
        drive(tmp);
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        tmp = '{ORR_, 1'b0, 1'b0, 1'b0, 32'h100, 32'h1, 32'h0, 1'b0, 4'b0000, 32'h0, 4'h0, 1'b0};
        drive(tmp);
        chk("bp first valid", {31'b0, ov1}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d valid", k), {31'b0, ov1}, 32'd1);
            chk($sformatf("bp hold%0d data", k), do1, 32'd5);
            chk($sformatf("bp hold%0d flags", k), {28'b0, fo1}, 32'hA);
            chk($sformatf("bp hold%0d in_ready", k), {31'b0, ir1}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp in_ready raised", {31'b0, ir1}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp next valid", {31'b0, ov1}, 32'd1);
        chk("bp next data", do1, 32'h101);
        chk("bp next flags", {28'b0, fo1}, 32'h0);
        @(posedge clk); #1;
        chk("bp drain", {31'b0, ov1}, 32'd0);

        // MLA latency on both multiplier configurations.
        tmp = '{4'h0, 1'b1, 1'b1, 1'b1, 32'h00010000, 32'h00010000, 32'h3, 1'b0, 4'b0011, 32'h0, 4'h0, 1'b0};
        drive(tmp);
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        chk("mla in_ready busy", {31'b0, ir1}, 32'd0);
        lat1 = 0; lat4 = 0;
        for (int k = 1; k <= 60; k++) begin
            if (ov1 && lat1 == 0) lat1 = k;
            if (ov4 && lat4 == 0) lat4 = k;
            if (lat1 != 0 && lat4 != 0) break;
            @(posedge clk); #1;
        end
        chk("mla latency x1", lat1, MLA_LAT1);
        chk("mla latency x4", lat4, MLA_LAT4);
        chk("mla data x1", do1, 32'h3);
        chk("mla data x4", do4, 32'h3);
        chk("mla flags x1", {28'b0, fo1}, 32'h3);
        chk("mla flags x4", {28'b0, fo4}, 32'h3);
        chk("mla wb x4", {31'b0, wb4}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("mla drain", {31'b0, ov1}, 32'd0);

        // Reset five cycles into a multiply.
        tmp = '{4'h0, 1'b1, 1'b0, 1'b1, 32'h3, 32'h5, 32'h0, 1'b0, 4'b1111, 32'h0, 4'h0, 1'b0};
        drive(tmp);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #2;
        chk("rst mid out_valid", {31'b0, ov1}, 32'd0);
        chk("rst mid dataout", do1, 32'd0);
        chk("rst mid flagsout", {28'b0, fo1}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst mid in_ready", {31'b0, ir1}, 32'd1);
        spur = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ov1 || ov4) spur++;
        end
        chk("rst mid no output", spur, 0);
        tmp = '{ADD_, 1'b0, 1'b0, 1'b0, 32'h2, 32'h3, 32'h0, 1'b0, 4'b0000, 32'h5, 4'b0000, 1'b1};
        run_vec(tmp, 99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
